ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: CLK in 1 (rising-edge clock); RST in 1 (asynchronous reset, active high).
REQ-002 The block SHALL have a flush input: flush in 1 (loads a bubble into the ID/EX register at the next edge).
REQ-003 It SHALL take these inputs from the decode stage:
- PCPlus4_in in 32
- rs_reg in 32, rt_reg in 32
- imm_signExtended in 32, imm_zeroExtended in 32
- rt_addr_in in 5, rd_addr_in in 5, shamt_in in 5
- jump_index_in in 26 (instruction[25:0])
REQ-004 It SHALL take these control inputs: RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD in 1 each; ALUopD in 6; ALUfunctD in 6.
REQ-005 It SHALL drive these outputs to MEM:
- RegWriteE out 1, MemtoRegE out 1, MemWriteE out 1
- ALUOutE out 32
- WriteDataE out 32 (registered rt_reg)
- WriteRegE out 5
REQ-006 It SHALL drive these outputs to IF:
- PCSrcE out 1 (redirect fetch)
- PCTargetE out 32
- OverflowE out 1 (signed-overflow flag)

Function
REQ-007 On every rising CLK, the ID/EX register SHALL capture all REQ-003/REQ-004 inputs; all outputs are combinational from this register, giving 1-cycle latency from decode input to EX output.
REQ-008 When flush=1 at an edge, the register SHALL load a bubble (all fields 0): no write, no memory write, PCSrcE=0.
REQ-009 flush SHALL take priority over new data; RST SHALL take priority over flush.
REQ-010 ALU results by instruction:
- lw/sw, add/addu/addi/addiu: ALUOutE = rs + B, where B = rt for R-type, imm_signExtended for I-type; sub/subu: rs - rt.
- and/or/xor/nor: bitwise on rs, rt; andi/ori/xori: rs op imm_zeroExtended.
- sll/srl/sra: rt shifted by shamt; sllv/srlv/srav: rt shifted by rs[4:0]; sra/srav shift arithmetically.
- slt: ALUOutE = 32'd1 if signed rs < rt, else 0.
- jal: ALUOutE = PCPlus4 (no delay slot).
REQ-011 Unlisted op/funct SHALL give ALUOutE=0 and pass the control bits through unchanged.
REQ-012 WriteRegE: jal -> 5'd31; else RegDst=1 -> rd; else rt.
REQ-013 For add/addi/sub, signed overflow SHALL set OverflowE=1 and force RegWriteE=0 in the same cycle; addu/addiu/subu never flag.
REQ-014 Branches: beq taken iff rs==rt; bne taken iff rs!=rt; PCTargetE = PCPlus4 + (imm_signExtended<<2), with 32-bit wrap-around.
REQ-015 Jumps: j/jal give PCTargetE = {PCPlus4[31:28], jump_index, 2'b00}; jr gives PCTargetE = rs.
REQ-016 PCSrcE = (BranchE & taken) | JumpE. When PCSrcE=0, PCTargetE = PCPlus4 of the registered instruction.
REQ-017 Register $0 is not special-cased here; writes to it are blocked downstream.

Reset
REQ-018 While RST=1, the ID/EX register SHALL asynchronously clear to the bubble of REQ-008, so every output reads 0.
REQ-019 RST asserted mid-operation SHALL discard the in-flight instruction.
REQ-020 The first edge after RST deasserts SHALL capture inputs normally.

Structure
REQ-021 Opcode and funct constants, plus the ALU-operation enumeration, SHALL live in a shared package mips_pkg that ID and EX both import.
REQ-022 Combinational ALU arithmetic (operation, A, B, shamt -> result, overflow) SHALL be one sub-module, alu.
REQ-023 Decode of op/funct into an ALU operation, the ID/EX register and branch/jump resolution SHALL stay in ex_stage.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- addi: rs=0x7FFFFFFF, imm=1 -> OverflowE=1, RegWriteE=0; same with addiu -> ALUOutE=0x80000000, RegWriteE=1, no flag.
- beq: rs=rt=5, PCPlus4=0x100, imm=0xFFFFFFFE -> PCSrcE=1, PCTargetE=0xF8; bne with the same operands -> PCSrcE=0.
- sra: rt=0x80000000, shamt=4 -> 0xF8000000; srl -> 0x08000000; sllv with rs=33 -> shift by 1.
- jal: PCPlus4=0x00400010, index=0x0100000 -> PCTargetE=0x00400000, WriteRegE=31, ALUOutE=0x00400010; jr with rs=0x1234 -> PCTargetE=0x1234.
- flush: add in flight with flush=1 at the capture edge -> the next cycle shows RegWriteE=0, MemWriteE=0, PCSrcE=0.
- RST: asserted between edges while sw is in EX -> MemWriteE drops to 0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants, ALU operation set and the ID/EX pipeline record.
// Imported by both the decode and execute stages.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_PASS_B
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm_s;
        logic [31:0] imm_z;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [4:0]  shamt;
        logic [25:0] jump_index;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        reg_dst;
        logic [5:0]  op;
        logic [5:0]  funct;
    } id_ex_t;

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle plus the EX results handed to MEM and IF.
// master = decode side, slave = execute stage.
interface ex_stage_if;
    logic [31:0] PCPlus4_in, rs_reg, rt_reg, imm_signExtended, imm_zeroExtended;
    logic [4:0]  rt_addr_in, rd_addr_in, shamt_in;
    logic [25:0] jump_index_in;
    logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD;
    logic [5:0]  ALUopD, ALUfunctD;

    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [31:0] ALUOutE, WriteDataE;
    logic [4:0]  WriteRegE;
    logic        PCSrcE, OverflowE;
    logic [31:0] PCTargetE;

    modport master (
        output PCPlus4_in, rs_reg, rt_reg, imm_signExtended, imm_zeroExtended,
               rt_addr_in, rd_addr_in, shamt_in, jump_index_in,
               RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD,
               ALUopD, ALUfunctD,
        input  RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE,
               PCSrcE, PCTargetE, OverflowE
    );

    modport slave (
        input  PCPlus4_in, rs_reg, rt_reg, imm_signExtended, imm_zeroExtended,
               rt_addr_in, rd_addr_in, shamt_in, jump_index_in,
               RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD,
               ALUopD, ALUfunctD,
        output RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE,
               PCSrcE, PCTargetE, OverflowE
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU: operation, A, B, shift amount -> result and signed-overflow flag.
// Shifts act on B; overflow is reported only for the trapping add/sub forms.
module alu
    import mips_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        overflow
);
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = a + b;
                overflow = (a[31] == b[31]) && (result[31] != a[31]);
            end
            ALU_ADDU: result = a + b;
            ALU_SUB: begin
                result   = a - b;
                overflow = (a[31] != b[31]) && (result[31] != a[31]);
            end
            ALU_SUBU:   result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_NOR:    result = ~(a | b);
            ALU_SLL:    result = b << shamt;
            ALU_SRL:    result = b >> shamt;
            ALU_SRA:    result = $signed(b) >>> shamt;
            ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, op/funct -> ALU decode, branch/jump resolution.
// All outputs are combinational from the register, so results appear one cycle after decode.
module ex_stage
    import mips_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       flush,
    ex_stage_if.slave  ex
);
    id_ex_t d, q;

    always_comb begin
        d.pc4        = ex.PCPlus4_in;
        d.rs         = ex.rs_reg;
        d.rt         = ex.rt_reg;
        d.imm_s      = ex.imm_signExtended;
        d.imm_z      = ex.imm_zeroExtended;
        d.rt_addr    = ex.rt_addr_in;
        d.rd_addr    = ex.rd_addr_in;
        d.shamt      = ex.shamt_in;
        d.jump_index = ex.jump_index_in;
        d.reg_write  = ex.RegWriteD;
        d.mem_to_reg = ex.MemtoRegD;
        d.mem_write  = ex.MemWriteD;
        d.branch     = ex.BranchD;
        d.jump       = ex.JumpD;
        d.reg_dst    = ex.RegDstD;
        d.op         = ex.ALUopD;
        d.funct      = ex.ALUfunctD;
    end

    // NOTE: sequential state uses non-blocking assignment; the all-zero record is the bubble.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)        q <= '0;
        else if (flush) q <= '0;
        else            q <= d;
    end

    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_result;
    logic [4:0]  alu_shamt;
    logic        alu_ovf;

    always_comb begin
        alu_op    = ALU_NONE;
        alu_b     = q.rt;
        alu_shamt = q.shamt;
        case (q.op)
            OP_RTYPE: begin
                case (q.funct)
                    F_ADD:  alu_op = ALU_ADD;
                    F_ADDU: alu_op = ALU_ADDU;
                    F_SUB:  alu_op = ALU_SUB;
                    F_SUBU: alu_op = ALU_SUBU;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLL:  alu_op = ALU_SLL;
                    F_SRL:  alu_op = ALU_SRL;
                    F_SRA:  alu_op = ALU_SRA;
                    F_SLLV: begin alu_op = ALU_SLL; alu_shamt = q.rs[4:0]; end
                    F_SRLV: begin alu_op = ALU_SRL; alu_shamt = q.rs[4:0]; end
                    F_SRAV: begin alu_op = ALU_SRA; alu_shamt = q.rs[4:0]; end
                    default: alu_op = ALU_NONE;
                endcase
            end
            OP_ADDI:                begin alu_op = ALU_ADD;    alu_b = q.imm_s; end
            OP_ADDIU, OP_LW, OP_SW: begin alu_op = ALU_ADDU;   alu_b = q.imm_s; end
            OP_ANDI:                begin alu_op = ALU_AND;    alu_b = q.imm_z; end
            OP_ORI:                 begin alu_op = ALU_OR;     alu_b = q.imm_z; end
            OP_XORI:                begin alu_op = ALU_XOR;    alu_b = q.imm_z; end
            OP_JAL:                 begin alu_op = ALU_PASS_B; alu_b = q.pc4;   end
            default:                alu_op = ALU_NONE;
        endcase
    end

    alu u_alu (
        .op       (alu_op),
        .a        (q.rs),
        .b        (alu_b),
        .shamt    (alu_shamt),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    logic        taken, pc_src, is_jr;
    logic [31:0] target;

    always_comb begin
        taken = 1'b0;
        case (q.op)
            OP_BEQ:  taken = (q.rs == q.rt);
            OP_BNE:  taken = (q.rs != q.rt);
            default: taken = 1'b0;
        endcase
    end

    assign is_jr  = (q.op == OP_RTYPE) && (q.funct == F_JR);
    assign pc_src = (q.branch & taken) | q.jump;

    // Fall-through target is the registered PC+4 so IF always sees a valid address.
    always_comb begin
        target = q.pc4;
        if (q.jump)
            target = is_jr ? q.rs : {q.pc4[31:28], q.jump_index, 2'b00};
        else if (q.branch && taken)
            target = q.pc4 + (q.imm_s << 2);
    end

    assign ex.ALUOutE    = alu_result;
    assign ex.OverflowE  = alu_ovf;
    assign ex.RegWriteE  = q.reg_write & ~alu_ovf;
    assign ex.MemtoRegE  = q.mem_to_reg;
    assign ex.MemWriteE  = q.mem_write;
    assign ex.WriteDataE = q.rt;
    assign ex.WriteRegE  = (q.op == OP_JAL) ? 5'd31 : (q.reg_dst ? q.rd_addr : q.rt_addr);
    assign ex.PCSrcE     = pc_src;
    assign ex.PCTargetE  = target;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a spec-level model of each instruction is compared every cycle,
// plus literal expectations for the called-out corner cases.
module tb_ex_stage;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [31:0] pc4, rs, rt, imms;
        logic [4:0]  rta, rda, sh;
        logic [25:0] idx;
        logic        rw, m2r, mw, br, j, rdst;
    } vec_t;

    typedef struct packed {
        logic [31:0] alu, wdata, target;
        logic [4:0]  wreg;
        logic        rw, m2r, mw, pcsrc, ovf;
    } out_t;

    localparam logic [5:0] CTL_R   = 6'b100001;
    localparam logic [5:0] CTL_I   = 6'b100000;
    localparam logic [5:0] CTL_LW  = 6'b110000;
    localparam logic [5:0] CTL_SW  = 6'b001000;
    localparam logic [5:0] CTL_BR  = 6'b000100;
    localparam logic [5:0] CTL_J   = 6'b000010;
    localparam logic [5:0] CTL_JAL = 6'b100010;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic flush = 1'b0;
    vec_t cur = '0;
    vec_t mreg = '0;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    ex_stage_if bus ();

    assign bus.PCPlus4_in       = cur.pc4;
    assign bus.rs_reg           = cur.rs;
    assign bus.rt_reg           = cur.rt;
    assign bus.imm_signExtended = cur.imms;
    assign bus.imm_zeroExtended = {16'h0000, cur.imms[15:0]};
    assign bus.rt_addr_in       = cur.rta;
    assign bus.rd_addr_in       = cur.rda;
    assign bus.shamt_in         = cur.sh;
    assign bus.jump_index_in    = cur.idx;
    assign bus.RegWriteD        = cur.rw;
    assign bus.MemtoRegD        = cur.m2r;
    assign bus.MemWriteD        = cur.mw;
    assign bus.BranchD          = cur.br;
    assign bus.JumpD            = cur.j;
    assign bus.RegDstD          = cur.rdst;
    assign bus.ALUopD           = cur.op;
    assign bus.ALUfunctD        = cur.funct;

    ex_stage dut (
        .CLK   (CLK),
        .RST   (RST),
        .flush (flush),
        .ex    (bus.slave)
    );

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] imms, input logic [31:0] pc4,
                                input logic [4:0] sh, input logic [25:0] idx,
                                input logic [5:0] ctl);
        vec_t v;
        v.op = op; v.funct = funct; v.rs = rs; v.rt = rt; v.imms = imms; v.pc4 = pc4;
        v.rta = 5'd8; v.rda = 5'd17; v.sh = sh; v.idx = idx;
        {v.rw, v.m2r, v.mw, v.br, v.j, v.rdst} = ctl;
        return v;
    endfunction

    function automatic logic in_s32(input longint s);
        return (s <= 64'sd2147483647) && (s >= -64'sd2147483648);
    endfunction

    // What each instruction must produce, straight from the instruction definitions.
    function automatic out_t model(input vec_t v);
        out_t o;
        logic [31:0] immz;
        longint s;
        logic taken;
        immz = {16'h0000, v.imms[15:0]};
        o = '0;
        case (v.op)
            6'h00: case (v.funct)
                6'h20: begin
                    o.alu = v.rs + v.rt;
                    s = longint'($signed(v.rs)) + longint'($signed(v.rt));
                    o.ovf = !in_s32(s);
                end
                6'h21: o.alu = v.rs + v.rt;
                6'h22: begin
                    o.alu = v.rs - v.rt;
                    s = longint'($signed(v.rs)) - longint'($signed(v.rt));
                    o.ovf = !in_s32(s);
                end
                6'h23: o.alu = v.rs - v.rt;
                6'h24: o.alu = v.rs & v.rt;
                6'h25: o.alu = v.rs | v.rt;
                6'h26: o.alu = v.rs ^ v.rt;
                6'h27: o.alu = ~(v.rs | v.rt);
                6'h00: o.alu = v.rt << v.sh;
                6'h02: o.alu = v.rt >> v.sh;
                6'h03: o.alu = $signed(v.rt) >>> v.sh;
                6'h04: o.alu = v.rt << (v.rs % 32);
                6'h06: o.alu = v.rt >> (v.rs % 32);
                6'h07: o.alu = $signed(v.rt) >>> (v.rs % 32);
                6'h2A: o.alu = ($signed(v.rs) < $signed(v.rt)) ? 32'd1 : 32'd0;
                default: o.alu = 32'd0;
            endcase
            6'h08: begin
                o.alu = v.rs + v.imms;
                s = longint'($signed(v.rs)) + longint'($signed(v.imms));
                o.ovf = !in_s32(s);
            end
            6'h09, 6'h23, 6'h2B: o.alu = v.rs + v.imms;
            6'h0C: o.alu = v.rs & immz;
            6'h0D: o.alu = v.rs | immz;
            6'h0E: o.alu = v.rs ^ immz;
            6'h03: o.alu = v.pc4;
            default: o.alu = 32'd0;
        endcase
        o.wreg  = (v.op == 6'h03) ? 5'd31 : (v.rdst ? v.rda : v.rta);
        o.rw    = v.rw && !o.ovf;
        o.m2r   = v.m2r;
        o.mw    = v.mw;
        o.wdata = v.rt;
        taken   = (v.op == 6'h04 && v.rs == v.rt) || (v.op == 6'h05 && v.rs != v.rt);
        o.pcsrc = (v.br && taken) || v.j;
        if (!o.pcsrc)
            o.target = v.pc4;
        else if (v.j)
            o.target = (v.op == 6'h00 && v.funct == 6'h08) ? v.rs : {v.pc4[31:28], v.idx, 2'b00};
        else
            o.target = v.pc4 + v.imms * 4;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // The instruction the EX stage should be holding: one edge behind the inputs.
    always @(posedge CLK or posedge RST) begin
        if (RST)        mreg <= '0;
        else if (flush) mreg <= '0;
        else            mreg <= cur;
    end

    always @(negedge CLK) begin
        out_t e;
        if (cmp_en) begin
            e = model(mreg);
            check("ALUOutE",    bus.ALUOutE,               e.alu);
            check("WriteDataE", bus.WriteDataE,            e.wdata);
            check("PCTargetE",  bus.PCTargetE,             e.target);
            check("WriteRegE",  {27'd0, bus.WriteRegE},    {27'd0, e.wreg});
            check("RegWriteE",  {31'd0, bus.RegWriteE},    {31'd0, e.rw});
            check("MemtoRegE",  {31'd0, bus.MemtoRegE},    {31'd0, e.m2r});
            check("MemWriteE",  {31'd0, bus.MemWriteE},    {31'd0, e.mw});
            check("PCSrcE",     {31'd0, bus.PCSrcE},       {31'd0, e.pcsrc});
            check("OverflowE",  {31'd0, bus.OverflowE},    {31'd0, e.ovf});
        end
    end

    task automatic step(input vec_t v, input logic fl);
        cur   = v;
        flush = fl;
        @(posedge CLK);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_alu",    bus.ALUOutE,               32'h0);
        check("reset_target", bus.PCTargetE,             32'h0);
        check("reset_rw",     {31'd0, bus.RegWriteE},    32'h0);
        cmp_en = 1'b1;
        #10 RST = 1'b0;

        step(mk(6'h08, 6'h00, 32'h7FFFFFFF, 32'h0, 32'h1, 32'h0, 5'd0, 26'd0, CTL_I), 1'b0);
        check("addi_ovf", {31'd0, bus.OverflowE}, 32'd1);
        check("addi_rw",  {31'd0, bus.RegWriteE}, 32'd0);
        step(mk(6'h09, 6'h00, 32'h7FFFFFFF, 32'h0, 32'h1, 32'h0, 5'd0, 26'd0, CTL_I), 1'b0);
        check("addiu_alu", bus.ALUOutE, 32'h80000000);
        check("addiu_rw",  {31'd0, bus.RegWriteE}, 32'd1);
        check("addiu_ovf", {31'd0, bus.OverflowE}, 32'd0);
        step(mk(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        step(mk(6'h00, 6'h22, 32'h80000000, 32'h1, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        check("sub_ovf", {31'd0, bus.OverflowE}, 32'd1);
        step(mk(6'h00, 6'h23, 32'h80000000, 32'h1, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        check("subu_alu", bus.ALUOutE, 32'h7FFFFFFF);

        step(mk(6'h04, 6'h00, 32'd5, 32'd5, 32'hFFFFFFFE, 32'h100, 5'd0, 26'd0, CTL_BR), 1'b0);
        check("beq_pcsrc",  {31'd0, bus.PCSrcE}, 32'd1);
        check("beq_target", bus.PCTargetE, 32'h000000F8);
        step(mk(6'h05, 6'h00, 32'd5, 32'd5, 32'hFFFFFFFE, 32'h100, 5'd0, 26'd0, CTL_BR), 1'b0);
        check("bne_pcsrc",  {31'd0, bus.PCSrcE}, 32'd0);
        check("bne_target", bus.PCTargetE, 32'h00000100);
        step(mk(6'h05, 6'h00, 32'd5, 32'd6, 32'h00000004, 32'h200, 5'd0, 26'd0, CTL_BR), 1'b0);

        step(mk(6'h00, 6'h03, 32'h0, 32'h80000000, 32'h0, 32'h0, 5'd4, 26'd0, CTL_R), 1'b0);
        check("sra", bus.ALUOutE, 32'hF8000000);
        step(mk(6'h00, 6'h02, 32'h0, 32'h80000000, 32'h0, 32'h0, 5'd4, 26'd0, CTL_R), 1'b0);
        check("srl", bus.ALUOutE, 32'h08000000);
        step(mk(6'h00, 6'h04, 32'd33, 32'h1, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        check("sllv", bus.ALUOutE, 32'h00000002);
        step(mk(6'h00, 6'h07, 32'd8, 32'h80000000, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        step(mk(6'h00, 6'h06, 32'd8, 32'h80000000, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        step(mk(6'h00, 6'h00, 32'h0, 32'h00000003, 32'h0, 32'h0, 5'd31, 26'd0, CTL_R), 1'b0);

        step(mk(6'h03, 6'h00, 32'h0, 32'h0, 32'h0, 32'h00400010, 5'd0, 26'h0100000, CTL_JAL), 1'b0);
        check("jal_target", bus.PCTargetE, 32'h00400000);
        check("jal_wreg",   {27'd0, bus.WriteRegE}, 32'd31);
        check("jal_alu",    bus.ALUOutE, 32'h00400010);
        step(mk(6'h00, 6'h08, 32'h1234, 32'h0, 32'h0, 32'h00400020, 5'd0, 26'd0, CTL_J), 1'b0);
        check("jr_target", bus.PCTargetE, 32'h00001234);
        step(mk(6'h02, 6'h00, 32'h0, 32'h0, 32'h0, 32'hA0000004, 5'd0, 26'h3FFFFFF, CTL_J), 1'b0);

        step(mk(6'h00, 6'h2A, 32'hFFFFFFFD, 32'd2, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        check("slt_neg", bus.ALUOutE, 32'd1);
        step(mk(6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        step(mk(6'h00, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        step(mk(6'h00, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        step(mk(6'h00, 6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        check("nor", bus.ALUOutE, 32'h000F000F);
        step(mk(6'h0C, 6'h00, 32'hFFFF0F0F, 32'h0, 32'hFFFF00FF, 32'h0, 5'd0, 26'd0, CTL_I), 1'b0);
        check("andi_zext", bus.ALUOutE, 32'h0000000F);
        step(mk(6'h0D, 6'h00, 32'h12340000, 32'h0, 32'hFFFF8001, 32'h0, 5'd0, 26'd0, CTL_I), 1'b0);
        step(mk(6'h0E, 6'h00, 32'h0000FFFF, 32'h0, 32'h000000FF, 32'h0, 5'd0, 26'd0, CTL_I), 1'b0);

        step(mk(6'h3F, 6'h00, 32'h11, 32'h22, 32'h33, 32'h44, 5'd0, 26'd0, CTL_LW), 1'b0);
        check("unlisted_alu", bus.ALUOutE, 32'h0);
        check("unlisted_m2r", {31'd0, bus.MemtoRegE}, 32'd1);

        step(mk(6'h00, 6'h20, 32'd1, 32'd2, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b1);
        check("flush_rw",    {31'd0, bus.RegWriteE}, 32'd0);
        check("flush_mw",    {31'd0, bus.MemWriteE}, 32'd0);
        check("flush_pcsrc", {31'd0, bus.PCSrcE},    32'd0);

        step(mk(6'h2B, 6'h00, 32'h100, 32'hDEAD, 32'h8, 32'h0, 5'd0, 26'd0, CTL_SW), 1'b0);
        check("sw_mw",  {31'd0, bus.MemWriteE}, 32'd1);
        check("sw_alu", bus.ALUOutE, 32'h108);
        #2 RST = 1'b1;
        #2;
        check("rst_async_mw",  {31'd0, bus.MemWriteE}, 32'd0);
        check("rst_async_alu", bus.ALUOutE, 32'h0);
        #2 RST = 1'b0;

        step(mk(6'h23, 6'h00, 32'h200, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd0, 26'd0, CTL_LW), 1'b0);
        check("post_rst_lw", bus.ALUOutE, 32'h1FC);
        step(mk(6'h00, 6'h21, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd0, 26'd0, CTL_R), 1'b0);
        step('0, 1'b0);
        @(posedge CLK);
        #6;

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
